// File: rtl/counter_cmd_sequencer.sv
// counter_cmd_sequencer
//   Two-requester round-robin command sequencer for one shared up/down
//   counter. Each requester issues CLEAR / LOAD / UP-N / DOWN-N over a
//   valid/ready handshake; the block drives the counter control pins and
//   returns the resulting count with a one-cycle response pulse.
// Ports
//   clk, rst                      clock, async active-high reset
//   reqN_valid/op/arg/ready       requester N command channel (N = 0,1)
//   rsp_valid/rsp_id/rsp_q        completion pulse, owner id, count value
//   busy                          high whenever not IDLE
//   cnt_clear/load/d/up_down/en   counter controls (Moore, from registers)
//   cnt_q                         registered count from the counter
module counter_cmd_sequencer #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 8,
  localparam int ARG_W = (WIDTH > STEP_W) ? WIDTH : STEP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [ARG_W-1:0] req0_arg,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [ARG_W-1:0] req1_arg,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_q,
  output logic             busy,
  output logic             cnt_clear,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_d,
  output logic             cnt_up_down,
  output logic             cnt_en,
  input  logic [WIDTH-1:0] cnt_q
);

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [ARG_W-1:0] arg;
  } cmd_t;

  state_t            state, state_n;
  logic [1:0]        op_r;
  logic              id_r;
  logic              last_grant;
  logic [STEP_W-1:0] rem;
  logic [1:0]        rst_sync;
  logic              rst_hold;

  cmd_t              sel;
  logic              grant;
  logic              acc;
  logic [STEP_W-1:0] sel_steps;
  logic              sel_zero_step;

  // Reset asserts immediately; release is held for two clk edges so the
  // FSM leaves reset cleanly aligned to the clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_hold = rst_sync[1];

  assign sel_steps     = sel.arg[STEP_W-1:0];
  // UP/DOWN by zero skips EXEC entirely.
  assign sel_zero_step = sel.op[1] && (sel_steps == '0);

  always_comb begin
    state_n    = state;
    grant      = 1'b0;
    acc        = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    sel        = '{op: req0_op, arg: req0_arg};
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = req1_valid;
    if (grant) sel = '{op: req1_op, arg: req1_arg};
    case (state)
      IDLE: begin
        if (!rst_hold && (req0_valid || req1_valid)) begin
          acc        = 1'b1;
          req0_ready = ~grant;
          req1_ready = grant;
          state_n    = sel_zero_step ? DONE : EXEC;
        end
      end
      EXEC: begin
        // CLEAR/LOAD are single-cycle; stepping ends on the last step.
        if (!op_r[1] || rem == STEP_W'(1)) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_r        <= '0;
      id_r        <= 1'b0;
      last_grant  <= 1'b1;
      rem         <= '0;
      cnt_d       <= '0;
      cnt_up_down <= 1'b0;
    end else if (rst_hold) begin
      state       <= IDLE;
      op_r        <= '0;
      id_r        <= 1'b0;
      last_grant  <= 1'b1;
      rem         <= '0;
      cnt_d       <= '0;
      cnt_up_down <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        op_r       <= sel.op;
        id_r       <= grant;
        last_grant <= grant;
        rem        <= sel_steps;
        if (sel.op == OP_LOAD) cnt_d <= sel.arg[WIDTH-1:0];
        // Direction only changes for commands that will actually step.
        if (sel.op[1] && !sel_zero_step) cnt_up_down <= ~sel.op[0];
      end else if (state == EXEC) begin
        rem <= rem - STEP_W'(1);
      end
    end
  end

  assign busy      = (state != IDLE);
  assign cnt_clear = (state == EXEC) && (op_r == OP_CLEAR);
  assign cnt_load  = (state == EXEC) && (op_r == OP_LOAD);
  assign cnt_en    = (state == EXEC) && op_r[1];
  assign rsp_valid = (state == DONE);
  assign rsp_id    = id_r;
  assign rsp_q     = (state == DONE) ? cnt_q : '0;

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
module tb_counter_cmd_sequencer;
  localparam int W = 8;
  localparam int A = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        rv   = '0;
  logic [1:0][1:0]   rop  = '0;
  logic [1:0][A-1:0] rarg = '0;
  logic rdy0, rdy1;
  wire  [1:0] rdy = {rdy1, rdy0};
  logic rsp_valid, rsp_id, busy;
  logic [W-1:0] rsp_q, cnt_d;
  logic cnt_clear, cnt_load, cnt_up_down, cnt_en;
  logic [W-1:0] cq = '0;

  counter_cmd_sequencer #(.WIDTH(W), .STEP_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(rv[0]), .req0_op(rop[0]), .req0_arg(rarg[0]), .req0_ready(rdy0),
    .req1_valid(rv[1]), .req1_op(rop[1]), .req1_arg(rarg[1]), .req1_ready(rdy1),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .busy(busy),
    .cnt_clear(cnt_clear), .cnt_load(cnt_load), .cnt_d(cnt_d),
    .cnt_up_down(cnt_up_down), .cnt_en(cnt_en), .cnt_q(cq)
  );

  // behavioural counter, not reset by the sequencer
  always @(posedge clk) begin
    if (cnt_clear)     cq <= '0;
    else if (cnt_load) cq <= cnt_d;
    else if (cnt_en)   cq <= cnt_up_down ? cq + 1'b1 : cq - 1'b1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic id; logic [W-1:0] q; } exp_t;
  exp_t     sb[$];
  int       acc_log[$];
  logic [W-1:0] mval  = '0;
  logic     mlast = 1'b1;

  // accept/response monitor + scoreboard
  always @(negedge clk) begin
    int   g;
    exp_t e;
    if (rst) begin
      sb.delete();
      mlast = 1'b1;
    end else begin
      if (busy) chk("rdy_busy", 32'(rdy), 32'd0);
      if (rdy != 2'b00) begin
        g = rdy[1] ? 1 : 0;
        if (rv == 2'b11) chk("tie_win", 32'(g), 32'(!mlast));
        chk("rdy_onehot", 32'(rdy[0] & rdy[1]), 32'd0);
        mlast = g[0];
        case (rop[g])
          2'b00:   mval = '0;
          2'b01:   mval = rarg[g][W-1:0];
          2'b10:   mval = mval + rarg[g];
          default: mval = mval - rarg[g];
        endcase
        sb.push_back('{id: g[0], q: mval});
        acc_log.push_back(g);
      end
      if (rsp_valid) begin
        if (sb.size() == 0) chk("rsp_unexp", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_q", 32'(rsp_q), 32'(e.q));
        end
      end
    end
  end

  task automatic send(input int id, input logic [1:0] op, input logic [A-1:0] arg);
    int n = 0;
    @(posedge clk); #1;
    rv[id] = 1'b1; rop[id] = op; rarg[id] = arg;
    forever begin
      @(negedge clk);
      if (rdy[id]) break;
      n++;
      if (n > 300) begin chk("send_timeout", 32'd1, 32'd0); break; end
    end
    @(posedge clk); #1;
    rv[id] = 1'b0;
    rop[id] = 2'($urandom);      // post-accept changes must be ignored
    rarg[id] = A'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy || sb.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 500) begin chk("idle_timeout", 32'd1, 32'd0); break; end
    end
  endtask

  function automatic logic [31:0] all_out();
    return 32'({busy, rsp_valid, rsp_id, rsp_q, cnt_clear, cnt_load, cnt_d,
                cnt_up_down, cnt_en, rdy});
  endfunction

  initial begin
    int en_n, b_n;
    // reset state
    repeat (2) @(posedge clk);
    #1 rv[0] = 1'b1;
    @(negedge clk);
    chk("rst_outputs", all_out(), 32'd0);
    rv[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // 1: LOAD 0x10
    send(0, 2'b01, 8'h10);
    @(negedge clk);
    chk("t1_load", 32'(cnt_load), 32'd1);
    chk("t1_d", 32'(cnt_d), 32'h10);
    chk("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_load_off", 32'(cnt_load), 32'd0);
    chk("t1_rsp", 32'(rsp_valid), 32'd1);
    chk("t1_q", 32'(rsp_q), 32'h10);
    @(negedge clk);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: UP 5
    send(0, 2'b10, 8'd5);
    en_n = 0; b_n = 0;
    for (int i = 0; i < 100; i++) begin
      if (i != 0) @(negedge clk);
      else @(negedge clk);
      if (!busy) break;
      b_n++;
      if (cnt_en) begin
        en_n++;
        chk("t2_dir", 32'(cnt_up_down), 32'd1);
      end
    end
    chk("t2_en_cycles", 32'(en_n), 32'd5);
    chk("t2_busy_cycles", 32'(b_n), 32'd6);
    chk("t2_count", 32'(cq), 32'h15);

    // 3: both requesters contend, grants must alternate
    acc_log.delete();
    fork
      begin send(0, 2'b10, 8'd1); send(0, 2'b10, 8'd2); send(0, 2'b01, 8'h33); end
      begin send(1, 2'b11, 8'd1); send(1, 2'b10, 8'd4); send(1, 2'b00, 8'd0); end
    join
    wait_idle();
    chk("t3_accepts", 32'(acc_log.size()), 32'd6);
    for (int i = 0; i < acc_log.size(); i++)
      chk("t3_alt", 32'(acc_log[i]), 32'(i % 2 == 0 ? 1 : 0));

    // 4: DOWN 0 then CLEAR
    send(0, 2'b01, 8'h5A); wait_idle();
    send(0, 2'b11, 8'd0);
    @(negedge clk);
    chk("t4_rsp_now", 32'(rsp_valid), 32'd1);
    chk("t4_no_en", 32'(cnt_en), 32'd0);
    chk("t4_q_hold", 32'(rsp_q), 32'h5A);
    wait_idle();
    send(1, 2'b00, 8'd0);
    @(negedge clk);
    chk("t4_clear", 32'(cnt_clear), 32'd1);
    wait_idle();

    // 5: wrap-around both directions
    send(0, 2'b01, 8'hFE); wait_idle();
    send(1, 2'b10, 8'd3);  wait_idle();
    chk("t5_wrap_up", 32'(cq), 32'h01);
    send(0, 2'b01, 8'h01); wait_idle();
    send(0, 2'b11, 8'd2);  wait_idle();
    chk("t5_wrap_dn", 32'(cq), 32'hFF);

    // 6: reset during cycle 3 of UP 10
    send(0, 2'b01, 8'h00); wait_idle();
    send(0, 2'b10, 8'd10);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1 chk("t6_async_out", all_out(), 32'd0);
    @(negedge clk);
    chk("t6_hold_out", all_out(), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    acc_log.delete();
    fork
      send(0, 2'b01, 8'h44);
      send(1, 2'b01, 8'h77);
    join
    wait_idle();
    chk("t6_accepts", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() > 0) chk("t6_first", 32'(acc_log[0]), 32'd0);
    chk("t6_count", 32'(cq), 32'h77);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1);
  end
endmodule
